// File: rtl/ro_puf_counter_ctrl_if.sv
// Bus between the enable-side controller and the RO-PUF counter controller:
// oscillator inputs and enable in, FSM state and signature results out.
interface ro_puf_counter_ctrl_if #(
    parameter int SIG_BITS = 127
);
    logic                roen;
    logic                ro_a;
    logic                ro_b;
    logic [1:0]          counter_ctrl_state;
    logic                sig_bit;
    logic                sig_bit_valid;
    logic [SIG_BITS-1:0] signature;
    logic [6:0]          sig_count;
    logic                sig_done;

    modport master (
        output roen, ro_a, ro_b,
        input  counter_ctrl_state, sig_bit, sig_bit_valid, signature, sig_count, sig_done
    );

    modport slave (
        input  roen, ro_a, ro_b,
        output counter_ctrl_state, sig_bit, sig_bit_valid, signature, sig_count, sig_done
    );
endinterface

// File: rtl/ro_puf_counter_ctrl.sv
// Ring-oscillator PUF counter controller: counts edges of two oscillators over a
// fixed window, compares them and shifts the resulting bit into a signature.
module ro_puf_counter_ctrl #(
    parameter int WINDOW   = 1024,
    parameter int CNT_W    = 16,
    parameter int SIG_BITS = 127
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ro_puf_counter_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COUNT   = 2'b01,
        ST_COMPARE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);
    localparam logic [6:0]  SIG_MAX  = 7'(SIG_BITS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_sync_a;
    logic [2:0]          r_sync_b;
    logic                w_edge_a;
    logic                w_edge_b;
    logic [CNT_W-1:0]    r_cnt_a;
    logic [CNT_W-1:0]    r_cnt_b;
    logic [15:0]         r_win;
    logic                r_sig_bit;
    logic                r_sig_valid;
    logic                r_sig_done;
    logic [SIG_BITS-1:0] r_signature;
    logic [6:0]          r_sig_count;
    logic [6:0]          w_cnt_inc;
    logic                w_full;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            sat_inc = v + CNT_W'(1);
        end else begin
            sat_inc = v;
        end
    endfunction

    // Bits [1:0] form the synchronizer; bit 2 is the previous synced value.
    assign w_edge_a  = r_sync_a[1] & ~r_sync_a[2];
    assign w_edge_b  = r_sync_b[1] & ~r_sync_b[2];
    assign w_cnt_inc = r_sig_count + 7'd1;
    assign w_full    = (r_sig_count == SIG_MAX);

    // Oscillator synchronizers and edge-history flops, running in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_a <= 3'b000;
            r_sync_b <= 3'b000;
        end else begin
            r_sync_a <= {r_sync_a[1:0], bus.ro_a};
            r_sync_b <= {r_sync_b[1:0], bus.ro_b};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a dropped enable in COUNT always wins over window expiry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.roen) w_state_nxt = ST_COUNT;
                else          w_state_nxt = ST_IDLE;
            end
            ST_COUNT: begin
                if (!bus.roen)             w_state_nxt = ST_IDLE;
                else if (r_win == WIN_LAST) w_state_nxt = ST_COMPARE;
                else                       w_state_nxt = ST_COUNT;
            end
            ST_COMPARE: w_state_nxt = ST_DONE;
            ST_DONE: begin
                if (!bus.roen) w_state_nxt = ST_IDLE;
                else           w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Edge counters and window counter; cleared while idle so every COUNT starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_win   <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt_a <= '0;
                    r_cnt_b <= '0;
                    r_win   <= 16'd0;
                end
                ST_COUNT: begin
                    r_cnt_a <= sat_inc(r_cnt_a, w_edge_a);
                    r_cnt_b <= sat_inc(r_cnt_b, w_edge_b);
                    r_win   <= r_win + 16'd1;
                end
                default: begin
                    r_cnt_a <= r_cnt_a;
                    r_cnt_b <= r_cnt_b;
                    r_win   <= r_win;
                end
            endcase
        end
    end

    // Bit decision and signature collection; signature and count freeze once full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_bit   <= 1'b0;
            r_sig_valid <= 1'b0;
            r_sig_done  <= 1'b0;
            r_signature <= '0;
            r_sig_count <= 7'd0;
        end else if (r_state == ST_COMPARE) begin
            r_sig_bit   <= (r_cnt_a > r_cnt_b);
            r_sig_valid <= 1'b1;
            if (!w_full) begin
                r_signature <= {r_signature[SIG_BITS-2:0], (r_cnt_a > r_cnt_b)};
                r_sig_count <= w_cnt_inc;
                r_sig_done  <= r_sig_done | (w_cnt_inc == SIG_MAX);
            end else begin
                r_signature <= r_signature;
                r_sig_count <= r_sig_count;
                r_sig_done  <= r_sig_done;
            end
        end else begin
            r_sig_valid <= 1'b0;
        end
    end

    assign bus.counter_ctrl_state = r_state;
    assign bus.sig_bit            = r_sig_bit;
    assign bus.sig_bit_valid      = r_sig_valid;
    assign bus.signature          = r_signature;
    assign bus.sig_count          = r_sig_count;
    assign bus.sig_done           = r_sig_done;
endmodule

// File: tb/tb_ro_puf_counter_ctrl.sv
// Randomized closed-loop bench: acts as the enable-side controller and predicts
// each signature bit from the recorded oscillator waveforms.
module tb_ro_puf_counter_ctrl;
    localparam int W    = 40;
    localparam int CW   = 4;
    localparam int SB   = 127;
    localparam int MAXC = 16384;
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst_n;

    ro_puf_counter_ctrl_if #(.SIG_BITS(SB)) bus ();

    ro_puf_counter_ctrl #(.WINDOW(W), .CNT_W(CW), .SIG_BITS(SB)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk;
    int          n_fail;
    int          cyc;
    int          n_valid;
    int          exp_valid;
    int          exp_cnt;
    logic [SB-1:0] exp_sig;
    logic        exp_bit;
    logic        hist_a [MAXC];
    logic        hist_b [MAXC];
    int          m_mode;
    int          m_ha;
    int          m_hb;
    int          m_pha;
    int          m_phb;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive the oscillators for the next rising edge, record them, sample at negedge.
    task automatic tick();
        int   n;
        logic a;
        logic b;
        n = cyc + 1;
        case (m_mode)
            0: begin
                a = 1'(((n + m_pha) / m_ha) % 2);
                b = 1'(((n + m_phb) / m_hb) % 2);
            end
            1: begin
                a = 1'(((n + m_pha) / m_ha) % 2);
                b = a;
            end
            2: begin
                a = 1'b1;
                b = 1'(n % 2);
            end
            3: begin
                a = 1'($urandom);
                b = 1'($urandom);
            end
            default: begin
                a = 1'b0;
                b = 1'b0;
            end
        endcase
        bus.ro_a = a;
        bus.ro_b = b;
        if (n < MAXC) begin
            hist_a[n] = a;
            hist_b[n] = b;
        end
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
        if (bus.sig_bit_valid === 1'b1) n_valid = n_valid + 1;
    endtask

    // Rising transitions seen two clocks late through the synchronizer, over the W open cycles.
    function automatic int edges(input bit use_a, input int p);
        int c;
        c = 0;
        for (int j = p + 1; j <= p + W; j++) begin
            if (use_a) begin
                if (hist_a[j-2] && !hist_a[j-3]) c = c + 1;
            end else begin
                if (hist_b[j-2] && !hist_b[j-3]) c = c + 1;
            end
        end
        if (c > CMAX) c = CMAX;
        return c;
    endfunction

    // One measurement: mode<0 picks randomly; abort_at>0 drops roen in that COUNT cycle;
    // stay leaves roen high in DONE.
    task automatic measure(input int mode, input int ha, input int hb, input int abort_at,
                           input int hold, input bit stay);
        int p;
        int ea;
        int eb;
        m_mode = (mode < 0) ? $urandom_range(0, 3) : mode;
        m_ha   = (ha > 0) ? ha : $urandom_range(1, 6);
        m_hb   = (hb > 0) ? hb : $urandom_range(1, 6);
        m_pha  = $urandom_range(0, 7);
        m_phb  = (mode == 0 && ha > 0) ? m_pha : $urandom_range(0, 7);
        bus.roen = 1'b1;
        tick();
        p = cyc;
        check_eq("state_count_entry", 128'(bus.counter_ctrl_state), 128'(2'b01));
        if (abort_at > 0) begin
            for (int i = 1; i < abort_at; i++) tick();
            bus.roen = 1'b0;
            tick();
            check_eq("abort_to_idle", 128'(bus.counter_ctrl_state), 128'(2'b00));
            tick();
            tick();
            check_eq("abort_count_hold", 128'(bus.sig_count), 128'(exp_cnt));
            check_eq("abort_no_valid", 128'(n_valid), 128'(exp_valid));
            return;
        end
        repeat (W - 1) tick();
        check_eq("state_count_last", 128'(bus.counter_ctrl_state), 128'(2'b01));
        tick();
        check_eq("state_compare", 128'(bus.counter_ctrl_state), 128'(2'b10));
        tick();
        ea = edges(1'b1, p);
        eb = edges(1'b0, p);
        exp_bit = (ea > eb);
        exp_valid = exp_valid + 1;
        if (exp_cnt < SB) begin
            exp_sig = {exp_sig[SB-2:0], exp_bit};
            exp_cnt = exp_cnt + 1;
        end
        check_eq("state_done", 128'(bus.counter_ctrl_state), 128'(2'b11));
        check_eq("valid_pulse", 128'(bus.sig_bit_valid), 128'(1'b1));
        check_eq("sig_bit", 128'(bus.sig_bit), 128'(exp_bit));
        check_eq("signature", 128'(bus.signature), 128'(exp_sig));
        check_eq("sig_count", 128'(bus.sig_count), 128'(exp_cnt));
        check_eq("sig_done", 128'(bus.sig_done), 128'(exp_cnt == SB));
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("done_hold", 128'(bus.counter_ctrl_state), 128'(2'b11));
            check_eq("valid_once", 128'(bus.sig_bit_valid), 128'(1'b0));
        end
        if (!stay) begin
            bus.roen = 1'b0;
            tick();
            check_eq("done_to_idle", 128'(bus.counter_ctrl_state), 128'(2'b00));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, 128'(bus.counter_ctrl_state), 128'(2'b00));
        check_eq({tag, "_valid"}, 128'(bus.sig_bit_valid), 128'(1'b0));
        check_eq({tag, "_bit"}, 128'(bus.sig_bit), 128'(1'b0));
        check_eq({tag, "_sig"}, 128'(bus.signature), 128'(0));
        check_eq({tag, "_count"}, 128'(bus.sig_count), 128'(0));
        check_eq({tag, "_done"}, 128'(bus.sig_done), 128'(1'b0));
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; n_valid = 0; exp_valid = 0; exp_cnt = 0;
        exp_sig = '0; exp_bit = 1'b0;
        m_mode = 4; m_ha = 1; m_hb = 1; m_pha = 0; m_phb = 0;
        for (int i = 0; i < MAXC; i++) begin
            hist_a[i] = 1'b0;
            hist_b[i] = 1'b0;
        end
        bus.roen = 1'b0;
        bus.ro_a = 1'b0;
        bus.ro_b = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) tick();
        check_eq("idle_after_reset", 128'(bus.counter_ctrl_state), 128'(2'b00));

        measure(0, 2, 4, 0, 2, 1'b0);   // A twice as fast as B
        measure(1, 3, 3, 0, 1, 1'b0);   // equal, in phase: tie
        measure(2, 1, 1, 0, 0, 1'b0);   // B saturates the counter
        measure(0, 0, 0, 3, 0, 1'b0);   // abort in COUNT cycle 3
        measure(-1, 0, 0, 0, 0, 1'b1);  // stay in DONE, then reset

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        bus.roen = 1'b0;
        m_mode = 4;
        exp_cnt = 0;
        exp_sig = '0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("idle_after_rst2", 128'(bus.counter_ctrl_state), 128'(2'b00));

        while (exp_cnt < SB) begin
            if ($urandom_range(0, 9) == 0) measure(-1, 0, 0, $urandom_range(1, W), 0, 1'b0);
            else                           measure(-1, 0, 0, 0, $urandom_range(0, 2), 1'b0);
        end
        repeat (3) measure(-1, 0, 0, 0, 0, 1'b0);

        check_eq("final_count", 128'(bus.sig_count), 128'(SB));
        check_eq("final_done", 128'(bus.sig_done), 128'(1'b1));
        check_eq("valid_total", 128'(n_valid), 128'(exp_valid));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
